// File: rtl/ob_ingress.sv
// ob_ingress: command validation, sequence stamping and FIFO ahead of ob_cntrl.
// Optional same-cycle bypass when empty: define OB_INGRESS_BYPASS_EN.
module ob_ingress #(
  parameter int N     = 8,
  parameter int SEQ_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [3:0]               in_opcode,
  input  logic [31:0]              in_uid,
  input  logic [15:0]              in_qty,
  input  logic [15:0]              in_price,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [3:0]               out_opcode,
  output logic [31:0]              out_uid,
  output logic [15:0]              out_qty,
  output logic [15:0]              out_price,
  output logic [SEQ_W-1:0]         out_seq,
  output logic                     rej_vld,
  output logic [31:0]              rej_uid,
  output logic [1:0]               rej_code,
  output logic [$clog2(N+1)-1:0]   occupancy
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N+1);

  typedef struct packed {
    logic [3:0]       op;
    logic [31:0]      uid;
    logic [15:0]      qty;
    logic [15:0]      price;
    logic [SEQ_W-1:0] seq;
  } ent_t;

  ent_t             r_mem [N];
  ent_t             r_last;
  ent_t             w_in;
  ent_t             w_head;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic [SEQ_W-1:0] r_seq;
  logic             r_rej_vld;
  logic [31:0]      r_rej_uid;
  logic [1:0]       r_rej_code;

  logic w_acc;
  logic w_badop;
  logic w_zq;
  logic w_nop;
  logic w_enq;
  logic w_rej;
  logic w_empty;
  logic w_byp;
  logic w_push;
  logic w_pop;

  assign in_rdy  = (r_cnt != CW'(N));
  assign w_acc   = in_vld & in_rdy;
  assign w_badop = (in_opcode > 4'd5);
  assign w_zq    = ((in_opcode == 4'd1) || (in_opcode == 4'd2))
                   && (in_qty == 16'd0);
  assign w_nop   = (in_opcode == 4'd0);
  assign w_enq   = w_acc & ~w_badop & ~w_zq & ~w_nop;
  assign w_rej   = w_acc & (w_badop | w_zq);
  assign w_empty = (r_cnt == '0);

  assign w_in = '{op: in_opcode, uid: in_uid, qty: in_qty,
                  price: in_price, seq: r_seq};

`ifdef OB_INGRESS_BYPASS_EN
  assign w_byp = w_empty & w_enq & out_rdy;
`else
  assign w_byp = 1'b0;
`endif

  // Bypassed commands are consumed in flight and never touch storage.
  assign w_push = w_enq & ~w_byp;
  assign w_pop  = ~w_empty & out_rdy;

  always_comb begin
    w_head = r_last;
    if (w_byp)         w_head = w_in;
    else if (!w_empty) w_head = r_mem[r_rd];
  end

  assign out_vld    = ~w_empty | w_byp;
  assign out_opcode = w_head.op;
  assign out_uid    = w_head.uid;
  assign out_qty    = w_head.qty;
  assign out_price  = w_head.price;
  assign out_seq    = w_head.seq;
  assign occupancy  = r_cnt;
  assign rej_vld    = r_rej_vld;
  assign rej_uid    = r_rej_uid;
  assign rej_code   = r_rej_code;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_seq      <= '0;
      r_last     <= '0;
      r_rej_vld  <= 1'b0;
      r_rej_uid  <= '0;
      r_rej_code <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_rd   <= r_rd + AW'(1);
        r_last <= w_head;
      end
      if (w_enq) r_seq <= r_seq + SEQ_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_rej_vld <= w_rej;
      if (w_rej) begin
        r_rej_uid  <= in_uid;
        r_rej_code <= w_badop ? 2'd1 : 2'd2;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      assert (!(w_pop && w_empty));
      assert (!(w_push && r_cnt == CW'(N)));
      assert (r_cnt <= CW'(N));
    end
  end
`endif

endmodule

// File: doc/ob_ingress.md
Name: ob_ingress

Overview:
Command ingress stage sitting directly upstream of ob_cntrl. It accepts order-book commands over a valid/ready interface and validates them. Legal commands are stamped with a monotonic sequence number and buffered in an N-entry FIFO. Commands are presented to ob_cntrl over a second valid/ready interface; illegal commands are diverted to a one-cycle reject pulse and never reach the controller.

Parameters:
N, 8, FIFO depth in entries; power of two, >= 2
SEQ_W, 16, width of sequence stamp; wraps modulo 2^SEQ_W

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; asynchronous assert, active-low (rst=0 resets), synchronous deassert handled upstream
in_vld  in  1  upstream command valid
in_rdy  out  1  ingress can accept (= !full)
in_opcode  in  4  0=NOP 1=BUY 2=SELL 3=POP_TOP_BID 4=POP_TOP_ASK 5=CANCEL, 6..15 illegal
in_uid  in  32  command identifier
in_qty  in  16  quantity
in_price  in  16  price
out_vld  out  1  command valid to ob_cntrl
out_rdy  in  1  ob_cntrl accepts
out_opcode  out  4  head opcode
out_uid  out  32  head uid
out_qty  out  16  head quantity
out_price  out  16  head price
out_seq  out  SEQ_W  head sequence stamp
rej_vld  out  1  one-cycle reject pulse
rej_uid  out  32  uid of rejected command
rej_code  out  2  1=bad opcode, 2=zero qty on BUY/SELL, 3=unused
occupancy  out  $clog2(N+1)  entries held

Behaviour:
- Handshake: input accepted on cycle with in_vld & in_rdy; output popped on cycle with out_vld & out_rdy. Payload is stable while out_vld=1 and not popped.
- in_rdy = (occupancy != N). It depends only on occupancy; there is no combinational path from out_rdy. When full, push is refused even if a pop happens the same cycle.
- Classification of an accepted command:
  - opcode 6..15 -> reject, code 1.
  - BUY/SELL with qty==0 -> reject, code 2.
  - NOP -> silently dropped; no reject, no seq increment.
  - Otherwise -> enqueue.
- Reject: rej_vld=1 for exactly the cycle after acceptance, with registered rej_uid/rej_code. Back-to-back rejects give consecutive pulses. Rejects do not consume FIFO space or seq numbers.
- Sequence: internal seq counter resets to 0. Each enqueue stamps the current value, then increments it; wraps 2^SEQ_W-1 -> 0.
- Latency: an enqueued command is visible on out_vld the cycle after acceptance (registered storage, read pointer indexes the array). No same-cycle pass-through.
- FIFO: write/read pointers $clog2(N) bits, wrap naturally. occupancy is updated registered:
  - +1 on enqueue only.
  - -1 on pop only.
  - Unchanged on simultaneous enqueue+pop, which is legal whenever not full, including occupancy=1.
- Empty: out_vld=0. out_* payload holds the last read value and is don't-care, but must not be X after reset.
- Reset (any time, including mid-burst): all pointers, occupancy and seq go to 0 immediately. Outputs after reset: in_rdy=1, out_vld=0, rej_vld=0, rej_uid=0, rej_code=0, occupancy=0, out_opcode/uid/qty/price/seq=0. Storage array contents are not reset.
- Assertions (sim only):
  - no pop when empty;
  - no push when full;
  - occupancy <= N.

Optional Feature:
OB_INGRESS_BYPASS_EN:
- Defined: when occupancy==0 and an enqueue-class command is accepted in the same cycle as out_rdy=1, the command is presented combinationally the same cycle and consumed without being written. out_vld/out_* are then muxed from in_*, and seq still increments.
- Undefined: strict one-cycle latency as above.
- in_rdy behaviour is identical in both builds.

Test Plan:
- Reset, then push BUY uid=0x10 qty=5 price=100 with out_rdy=1 -> out_vld cycle+1 with uid=0x10, seq=0; occupancy returns to 0 (bypass build: out_vld same cycle).
- out_rdy=0, push 8 BUY commands uids 1..8 -> in_rdy drops after 8th, occupancy=8. A 9th in_vld is held and not accepted. Release out_rdy -> uids 1..8 drain in order with seq 0..7.
- Push opcode=9 uid=0xAA, then SELL qty=0 uid=0xBB -> rej_vld pulses on two consecutive cycles with codes 1 then 2; occupancy stays 0; the next legal command gets seq=0.
- Push NOP then CANCEL uid=0x55 -> only CANCEL emerges, seq=0, no rej_vld.
- Occupancy=1 with simultaneous push+pop for 20 cycles -> occupancy stays 1, order preserved. After 2^16 enqueues, seq wraps 0xFFFF -> 0x0000.
- Assert rst=0 mid-drain with occupancy=5 -> same cycle: out_vld=0, occupancy=0, in_rdy=1. After release, a new push gets seq=0.
